// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_pkg
// Brief    : Shared types, constants and GF(2^8) helpers for the AES
//            decryption datapath (inverse MixColumns sequencer).
// Revision : 1.0 - initial release
// ============================================================================
package aes_dec_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    // Reduction constant of the AES field polynomial x^8+x^4+x^3+x+1
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Multiply by x (0x02) in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // 0x09 = 8 + 1
    function automatic logic [7:0] gmul9(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ a;
    endfunction

    // 0x0B = 8 + 2 + 1
    function automatic logic [7:0] gmulb(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    // 0x0D = 8 + 4 + 1
    function automatic logic [7:0] gmuld(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    // 0x0E = 8 + 4 + 2
    function automatic logic [7:0] gmule(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_mixcol_lane.sv
`default_nettype none
// ============================================================================
// Module   : inv_mixcol_lane
// Brief    : Combinational inverse MixColumns for one 32-bit column.
//            Byte a0 (row 0) sits in the MSB byte of the column.
// Revision : 1.0 - initial release
// ============================================================================
module inv_mixcol_lane
    import aes_dec_pkg::*;
(
    input  col_t i_col,
    output col_t o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    // Each output row is the {e,b,d,9} row rotated right by its row index
    assign o_col[31:24] = gmule(w_a0) ^ gmulb(w_a1) ^ gmuld(w_a2) ^ gmul9(w_a3);
    assign o_col[23:16] = gmul9(w_a0) ^ gmule(w_a1) ^ gmulb(w_a2) ^ gmuld(w_a3);
    assign o_col[15:8]  = gmuld(w_a0) ^ gmul9(w_a1) ^ gmule(w_a2) ^ gmulb(w_a3);
    assign o_col[7:0]   = gmulb(w_a0) ^ gmuld(w_a1) ^ gmul9(w_a2) ^ gmule(w_a3);

endmodule
`default_nettype wire

// File: rtl/inv_mixcol_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_mixcol_seq
// Brief    : Column-serial AES inverse MixColumns. A 128-bit state is taken
//            over valid/ready, pushed through COLS_PER_CYCLE shared column
//            lanes over NUM_PASSES cycles, then offered downstream.
//            Optional macro INV_MIXCOL_BYPASS_EN adds a 'bypass' input that
//            passes the state through unchanged with identical timing
//            (last-round path).
// Revision : 1.0 - initial release
// ============================================================================
module inv_mixcol_seq
    import aes_dec_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef INV_MIXCOL_BYPASS_EN
    input  logic         bypass,
`endif
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NUM_PASSES = 4 / COLS_PER_CYCLE;
    localparam int CNT_W      = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NUM_PASSES - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_t             r_state;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_src;
    state_t           r_res;
    state_t           r_out_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
`ifdef INV_MIXCOL_BYPASS_EN
    logic             r_byp;
`endif

    logic [1:0] w_col_idx  [COLS_PER_CYCLE];
    col_t       w_lane_in  [COLS_PER_CYCLE];
    col_t       w_lane_raw [COLS_PER_CYCLE];
    col_t       w_lane_out [COLS_PER_CYCLE];
    state_t     w_res_next;

    // Column c lives at bits [127-32c -: 32], i.e. base offset {~c, 5'b0}
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign w_col_idx[g] = 2'(int'(r_cnt) * COLS_PER_CYCLE + g);
        assign w_lane_in[g] = r_src[{~w_col_idx[g], 5'd0} +: 32];

        inv_mixcol_lane u_lane (
            .i_col (w_lane_in[g]),
            .o_col (w_lane_raw[g])
        );

`ifdef INV_MIXCOL_BYPASS_EN
        assign w_lane_out[g] = r_byp ? w_lane_in[g] : w_lane_raw[g];
`else
        assign w_lane_out[g] = w_lane_raw[g];
`endif
    end

    // Merge this pass's lane results into the partial result
    always_comb begin
        w_res_next = r_res;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            w_res_next[{~w_col_idx[i], 5'd0} +: 32] = w_lane_out[i];
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_src       <= '0;
            r_res       <= '0;
            r_out_state <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef INV_MIXCOL_BYPASS_EN
            r_byp       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_src      <= in_state;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef INV_MIXCOL_BYPASS_EN
                        r_byp      <= bypass;
`endif
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_res <= w_res_next;
                    if (r_cnt == LAST_PASS) begin
                        // out_state is only loaded from a complete result
                        r_out_state <= w_res_next;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_inv_mixcol_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_mixcol_seq
// Brief    : Self-checking bench for inv_mixcol_seq. Three instances cover
//            COLS_PER_CYCLE = 1, 2, 4. Expected results go into a scoreboard
//            at acceptance and are compared when the DUT hands them off.
//            Build with INV_MIXCOL_BYPASS_EN to exercise the bypass path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_mixcol_seq;

    localparam int CPC [3] = '{1, 2, 4};

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    typedef struct packed {
        logic [1:0]   k;
        logic [127:0] exp;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];
`ifdef INV_MIXCOL_BYPASS_EN
    logic         bypass    [3];
`endif

    int  n_tests = 0;
    int  n_fail  = 0;
    sb_t sb_q[$];
    vec_t tv[6];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        inv_mixcol_seq #(.COLS_PER_CYCLE(CPC[k])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
`ifdef INV_MIXCOL_BYPASS_EN
            .bypass    (bypass[k]),
`endif
            .in_state  (in_state[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_state (out_state[k]),
            .busy      (busy[k])
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake seen at the negedge completes on the next posedge
    for (genvar k = 0; k < 3; k++) begin : g_mon
        always @(negedge clk) begin
            sb_t e;
            if (!rst && out_valid[k] && out_ready[k]) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 128'(out_valid[k]), 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_instance", 128'(k), 128'(e.k));
                    chk("out_state", out_state[k], e.exp);
                end
            end
        end
    end

    // Independent forward MixColumns model, used to build round-trip stimulus
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    // Present s on instance k until accepted; optionally record its expected result
    task automatic send(input int k, input logic [127:0] s, input logic [127:0] exp,
                        input bit push, input bit hold);
        bit  ok;
        sb_t e;
        ok = 1'b0;
        in_valid[k] = 1'b1;
        in_state[k] = s;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready[k]) begin
                ok = 1'b1;
                if (push) begin
                    e.k   = 2'(k);
                    e.exp = exp;
                    sb_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 128'(in_ready[k]), 128'd1);
        if (!hold) in_valid[k] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    endtask

    // Cycles from the acceptance edge until out_valid is seen high
    task automatic check_latency(input int k, input int exp_lat, input string name);
        int lat;
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[k]) lat = c;
        end
        chk(name, 128'(lat), 128'(exp_lat));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] x;

        tv[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        tv[1] = '{128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6, 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5};
        tv[2] = '{128'h01010101_01010101_01010101_01010101, 128'h01010101_01010101_01010101_01010101};
        tv[3] = '{128'h0, 128'h0};
        tv[4] = '{{128{1'b1}}, {128{1'b1}}};
        tv[5] = '{128'hc6c6c6c6_8e4da1bc_9fdc589d_01010101, 128'hc6c6c6c6_db135345_f20a225c_01010101};

        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            out_ready[k] = 1'b1;
`ifdef INV_MIXCOL_BYPASS_EN
            bypass[k]    = 1'b0;
`endif
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready",  128'(in_ready[k]),  128'd1);
            chk("reset_out_valid", 128'(out_valid[k]), 128'd0);
            chk("reset_out_state", out_state[k],       128'd0);
            chk("reset_busy",      128'(busy[k]),      128'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency for each lane count
        for (int k = 0; k < 3; k++) begin
            send(k, tv[0].din, tv[0].dout, 1'b1, 1'b0);
            check_latency(k, 4 / CPC[k], "latency");
            drain();
        end

        // Vector table on all instances
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 6; v++) begin
                send(k, tv[v].din, tv[v].dout, 1'b1, 1'b0);
            end
            drain();
        end

        // Backpressure: result holds, new input is ignored
        out_ready[0] = 1'b0;
        send(0, tv[0].din, tv[0].dout, 1'b1, 1'b0);
        check_latency(0, 4, "bp_latency");
        in_valid[0] = 1'b1;
        in_state[0] = tv[1].din;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_out_state", out_state[0],       tv[0].dout);
            chk("bp_in_ready",  128'(in_ready[0]),  128'd0);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        chk("bp_release_out_valid", 128'(out_valid[0]), 128'd0);
        chk("bp_release_in_ready",  128'(in_ready[0]),  128'd1);
        chk("bp_hold_out_state",    out_state[0],       tv[0].dout);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_no_capture", 128'(out_valid[0]), 128'd0);
        out_ready[0] = 1'b1;
        drain();

        // Back-to-back with in_valid held high
        send(0, tv[1].din, tv[1].dout, 1'b1, 1'b1);
        send(0, tv[2].din, tv[2].dout, 1'b1, 1'b1);
        in_valid[0] = 1'b0;
        drain();
        repeat (10) @(posedge clk);
        #1;

        // Reset during RUN at pass 2 aborts the job
        send(0, tv[0].din, tv[0].dout, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
        chk("abort_in_ready",  128'(in_ready[0]),  128'd1);
        chk("abort_busy",      128'(busy[0]),      128'd0);
        chk("abort_out_state", out_state[0],       128'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_output", 128'(out_valid[0]), 128'd0);
        send(0, tv[5].din, tv[5].dout, 1'b1, 1'b0);
        drain();

        // Round trip through the forward model
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 1000; n++) begin
                x = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(k, fwd_mix(x), x, 1'b1, 1'b0);
            end
            drain();
        end

`ifdef INV_MIXCOL_BYPASS_EN
        // Bypass: unchanged state with the normal latency
        bypass[0] = 1'b1;
        send(0, 128'h00112233445566778899aabbccddeeff, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0);
        bypass[0] = 1'b0;
        check_latency(0, 4, "bypass_latency");
        drain();
        send(0, tv[0].din, tv[0].dout, 1'b1, 1'b0);
        drain();
`endif

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
